// File: rtl/m68k_periph_pkg.sv
`default_nettype none
//----------------------------------------------------------------------------
//  Module      : m68k_periph_pkg
//  Description : Shared constants for the 68k 16-bit peripheral bus blocks:
//                timer register indices, CTRL bit positions and the
//                address-strobe edge-detect helper used by the bus slave.
//  Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
package m68k_periph_pkg;

   // Timer register indices, decoded from addr[7:1]
   typedef enum logic [6:0] {
      TMR_CTRL      = 7'd0,
      TMR_RELOAD_HI = 7'd1,
      TMR_RELOAD_LO = 7'd2,
      TMR_COUNT_HI  = 7'd3,
      TMR_COUNT_LO  = 7'd4,
      TMR_STATUS    = 7'd5,
      TMR_PRESC     = 7'd6
   } tmr_reg_e;

   // CTRL bit positions
   localparam int CTRL_RUN   = 0;
   localparam int CTRL_AUTO  = 1;
   localparam int CTRL_IRQEN = 2;

   // STATUS bit positions
   localparam int STATUS_EXP = 0;

   // {previous as, current as} pattern that opens a new access
   localparam logic [1:0] AS_RISE = 2'b01;

   // True on the first cycle of an address-strobe assertion
   function automatic logic as_rising(input logic prev_as, input logic cur_as);
      return ({prev_as, cur_as} == AS_RISE);
   endfunction

endpackage
`default_nettype wire

// File: rtl/m68k_bus_slave_if.sv
`default_nettype none
//----------------------------------------------------------------------------
//  Module      : m68k_bus_slave_if
//  Description : Generic 68k peripheral bus slave front end. Detects the
//                start of an access (as rising), decodes addr[7:1] against
//                the number of implemented registers, produces the one-shot
//                ack one clock later and the per-lane write / read enables
//                for the start cycle.
//  Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
module m68k_bus_slave_if #(
   parameter int NUM_REGS = 6
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       i_as,
   input  logic       i_rw,
   input  logic       i_uds,
   input  logic       i_lds,
   input  logic [7:0] i_addr,
   output logic       o_ack,
   output logic [6:0] o_reg_idx,
   output logic       o_rd_en,
   output logic       o_wr_hi,
   output logic       o_wr_lo
);
   import m68k_periph_pkg::*;

   logic r_as_d;
   logic r_ack;
   logic w_start;
   logic w_decoded;
   logic w_access;
   logic w_unused_addr0;

   // Byte address bit 0 carries no information on a 16-bit bus
   assign w_unused_addr0 = i_addr[0];

   assign w_start   = as_rising(r_as_d, i_as);
   assign w_decoded = (32'(i_addr[7:1]) < NUM_REGS);
   assign w_access  = w_start & w_decoded;

   assign o_reg_idx = i_addr[7:1];
   assign o_rd_en   = w_access & i_rw;
   assign o_wr_hi   = w_access & ~i_rw & i_uds;
   assign o_wr_lo   = w_access & ~i_rw & i_lds;
   assign o_ack     = r_ack;

   // Strobe history and one-shot ack; unmapped addresses never ack
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_as_d <= 1'b0;
         r_ack  <= 1'b0;
      end else begin
         r_as_d <= i_as;
         r_ack  <= w_access;
      end
   end

endmodule
`default_nettype wire

// File: rtl/m68k_timer.sv
`default_nettype none
//----------------------------------------------------------------------------
//  Module      : m68k_timer
//  Description : 32-bit down-counting timer on the 68k peripheral bus.
//                One-shot and auto-reload modes, sticky EXP status flag and
//                a one-clock irq pulse (interrupt controller interrupts[2]).
//                Optional feature macro M68K_TIMER_PRESCALER_EN adds a
//                software-programmable prescaler register at index 6.
//  Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
module m68k_timer #(
   parameter int          PRESCALE   = 16,
   parameter logic [31:0] RELOAD_RST = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] data_write,
   output logic [15:0] data_read,
   input  logic [7:0]  addr,
   input  logic        uds,
   input  logic        lds,
   input  logic        rw,
   input  logic        as,
   output logic        ack,
   output logic        irq
);
   import m68k_periph_pkg::*;

`ifdef M68K_TIMER_PRESCALER_EN
   localparam int c_num_regs = 7;
`else
   localparam int c_num_regs = 6;
   localparam logic [15:0] c_psc_limit = 16'(PRESCALE - 1);
`endif

   logic [6:0]  w_idx;
   logic        w_rd_en;
   logic        w_wr_hi;
   logic        w_wr_lo;
   logic        w_run;
   logic        w_tick;
   logic        w_expire;
   logic        w_ctrl_wr;
   logic        w_run_start;
   logic        w_exp_clr;
   logic [15:0] w_psc_limit;
   logic [15:0] w_rd_word;
   logic [15:0] w_lane_mask;

   logic [2:0]  r_ctrl;
   logic [31:0] r_reload;
   logic [31:0] r_count;
   logic [15:0] r_shadow;
   logic        r_exp;
   logic        r_irq;
   logic [15:0] r_data_read;
   logic [15:0] r_psc_cnt;
`ifdef M68K_TIMER_PRESCALER_EN
   logic [15:0] r_presc;
   logic [15:0] r_presc_act;
`endif

   m68k_bus_slave_if #(
      .NUM_REGS (c_num_regs)
   ) u_bus (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_as      (as),
      .i_rw      (rw),
      .i_uds     (uds),
      .i_lds     (lds),
      .i_addr    (addr),
      .o_ack     (ack),
      .o_reg_idx (w_idx),
      .o_rd_en   (w_rd_en),
      .o_wr_hi   (w_wr_hi),
      .o_wr_lo   (w_wr_lo)
   );

`ifdef M68K_TIMER_PRESCALER_EN
   assign w_psc_limit = r_presc_act;
`else
   assign w_psc_limit = c_psc_limit;
`endif

   assign w_run       = r_ctrl[CTRL_RUN];
   assign w_tick      = w_run & (r_psc_cnt == w_psc_limit);
   assign w_expire    = w_tick & (r_count == 32'd0);
   assign w_ctrl_wr   = w_wr_lo & (w_idx == TMR_CTRL);
   assign w_run_start = w_ctrl_wr & data_write[CTRL_RUN] & ~w_run;
   assign w_exp_clr   = w_wr_lo & (w_idx == TMR_STATUS) & data_write[STATUS_EXP];
   assign w_lane_mask = {{8{uds}}, {8{lds}}};

   assign data_read = r_data_read;
   assign irq       = r_irq;

   // Prescaler: free-runs 0..limit while RUN, parked at 0 when stopped
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_psc_cnt <= 16'h0000;
      end else if (!w_run || w_tick) begin
         r_psc_cnt <= 16'h0000;
      end else begin
         r_psc_cnt <= r_psc_cnt + 16'd1;
      end
   end

`ifdef M68K_TIMER_PRESCALER_EN
   // PRESC register; the active limit only follows it at a wrap or while stopped
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_presc     <= 16'(PRESCALE);
         r_presc_act <= 16'(PRESCALE);
      end else begin
         if (w_wr_hi && (w_idx == TMR_PRESC)) r_presc[15:8] <= data_write[15:8];
         if (w_wr_lo && (w_idx == TMR_PRESC)) r_presc[7:0]  <= data_write[7:0];
         if (!w_run || w_tick) r_presc_act <= r_presc;
      end
   end
`endif

   // CTRL: a bus write overrides the one-shot auto-stop in the same cycle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ctrl <= 3'b000;
      end else if (w_ctrl_wr) begin
         r_ctrl <= data_write[2:0];
      end else if (w_expire && !r_ctrl[CTRL_AUTO]) begin
         r_ctrl[CTRL_RUN] <= 1'b0;
      end
   end

   // RELOAD: byte-lane writes; an expiry in the same cycle sees the old value
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_reload <= RELOAD_RST;
      end else begin
         if (w_wr_hi && (w_idx == TMR_RELOAD_HI)) r_reload[31:24] <= data_write[15:8];
         if (w_wr_lo && (w_idx == TMR_RELOAD_HI)) r_reload[23:16] <= data_write[7:0];
         if (w_wr_hi && (w_idx == TMR_RELOAD_LO)) r_reload[15:8]  <= data_write[15:8];
         if (w_wr_lo && (w_idx == TMR_RELOAD_LO)) r_reload[7:0]   <= data_write[7:0];
      end
   end

   // COUNT: load on RUN 0->1, decrement per tick, reload or park on expiry
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_count <= 32'd0;
      end else if (w_run_start) begin
         r_count <= r_reload;
      end else if (w_expire) begin
         if (r_ctrl[CTRL_AUTO]) r_count <= r_reload;
      end else if (w_tick) begin
         r_count <= r_count - 32'd1;
      end
   end

   // EXP sticky flag: setting by expiry beats a simultaneous W1C
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_exp <= 1'b0;
      end else if (w_expire) begin
         r_exp <= 1'b1;
      end else if (w_exp_clr) begin
         r_exp <= 1'b0;
      end
   end

   // irq: single-clock pulse following an enabled expiry
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_irq <= 1'b0;
      end else begin
         r_irq <= w_expire & r_ctrl[CTRL_IRQEN];
      end
   end

   // Read mux for the access start cycle
   always_comb begin
      w_rd_word = 16'h0000;
      case (w_idx)
         TMR_CTRL:      w_rd_word = {13'h0000, r_ctrl};
         TMR_RELOAD_HI: w_rd_word = r_reload[31:16];
         TMR_RELOAD_LO: w_rd_word = r_reload[15:0];
         TMR_COUNT_HI:  w_rd_word = r_count[31:16];
         TMR_COUNT_LO:  w_rd_word = r_shadow;
         TMR_STATUS:    w_rd_word = {15'h0000, r_exp};
`ifdef M68K_TIMER_PRESCALER_EN
         TMR_PRESC:     w_rd_word = r_presc;
`endif
         default:       w_rd_word = 16'h0000;
      endcase
   end

   // Read data register (valid in the ack cycle only) and COUNT_LO snapshot
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_data_read <= 16'h0000;
         r_shadow    <= 16'h0000;
      end else begin
         r_data_read <= w_rd_en ? (w_rd_word & w_lane_mask) : 16'h0000;
         if (w_rd_en && (w_idx == TMR_COUNT_HI)) r_shadow <= r_count[15:0];
      end
   end

endmodule
`default_nettype wire

// File: doc/m68k_timer.md
Name: m68k_timer

Overview:
- 32-bit down-counting timer peripheral on the 68k 16-bit peripheral bus; the direct upstream source of the interrupt controller's timer line (interrupts[2], Auto Int 2).
- Software loads a reload value and starts the counter. On expiry the block sets a sticky status flag and emits a one-clock interrupt pulse to the interrupt controller.
- Supports one-shot and auto-reload modes.

Parameters:
- PRESCALE, 16, clk cycles per counter tick (minimum 1; 1 means the counter ticks every clk).
- RELOAD_RST, 32'hFFFF_FFFF, reset value of RELOAD.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- data_write  in  16  write data; uds selects [15:8], lds selects [7:0]
- data_read  out  16  read data; valid only in the ack cycle, 0 otherwise
- addr  in  8  byte address; decoded on addr[7:1]
- uds  in  1  upper byte lane strobe
- lds  in  1  lower byte lane strobe
- rw  in  1  1 = read, 0 = write
- as  in  1  address strobe (high = access active, block already selected)
- ack  out  1  one-clock transfer acknowledge
- irq  out  1  one-clock expiry pulse, to interrupt controller interrupts[2]

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
  - Reset values: ack=0, data_read=0, irq=0, CTRL=0, STATUS=0, COUNT=0, RELOAD=RELOAD_RST, prescaler counter=0.
  - Reset asserted mid-transfer or mid-count aborts immediately with no ack.
- Register map (addr[7:1]):
  - 0 CTRL (RW, lds only): bit0 RUN, bit1 AUTO, bit2 IRQEN; other bits read 0.
  - 1 RELOAD_HI [31:16] (RW).
  - 2 RELOAD_LO [15:0] (RW).
  - 3 COUNT_HI (RO). A read returns COUNT[31:16] and latches COUNT[15:0] into a shadow register.
  - 4 COUNT_LO (RO). A read returns the shadow latched by the last COUNT_HI read.
  - 5 STATUS: bit0 EXP. Write 1 to clear (lds only).
- Bus handshake:
  - An access starts on the first cycle in which as=1 and the previous cycle had as=0.
  - ack=1 exactly one clock later, once per as assertion, for decoded addresses 0..5 only.
  - Unmapped addresses get no ack; the bus timeout handles them.
  - Writes take effect in the ack cycle and touch only the byte lanes strobed.
  - Reads drive only the strobed lanes; unstrobed lanes read 0.
  - Writes to RO registers are acked and ignored.
- Prescaler:
  - While RUN=1, a counter runs 0..PRESCALE-1; tick is asserted when it wraps.
  - While RUN=0, the prescaler is held at 0.
- Run control:
  - A RUN 0->1 write loads COUNT<=RELOAD and clears the prescaler.
  - Writing RUN=1 while already running has no effect on COUNT.
  - A RUN=0 write stops the counter; COUNT holds its value.
- Counting:
  - On tick with COUNT!=0: COUNT<=COUNT-1.
  - On tick with COUNT==0 (expiry):
    - EXP<=1.
    - irq=1 for the next single clock if IRQEN=1.
    - If AUTO=1: COUNT<=RELOAD; otherwise RUN<=0 and COUNT stays 0.
  - Expiry period is (RELOAD+1)*PRESCALE clk cycles. RELOAD=0 expires every tick.
- Simultaneous events:
  - Expiry in the same cycle as an EXP W1C write: EXP stays 1 (set wins).
  - Expiry in the same cycle as a CTRL write: the CTRL write wins for RUN/AUTO/IRQEN; EXP is still set.
  - A RELOAD write in the expiry cycle: the old RELOAD is loaded.
- irq is independent of EXP clearing. It never stays high for more than one clock.

Optional Feature:
- Macro: M68K_TIMER_PRESCALER_EN.
- Defined:
  - Adds register addr[7:1]=6 PRESC (RW, 16 bit), reset value PRESCALE.
  - The tick period is PRESC+1 clk cycles. A PRESC write takes effect at the next prescaler wrap.
- Undefined:
  - Address 6 is unmapped (no ack).
  - The period is fixed at the PRESCALE parameter.

Decomposition:
- Shared package m68k_periph_pkg holds:
  - Register index constants (TMR_CTRL=0 .. TMR_STATUS=5, TMR_PRESC=6).
  - CTRL bit positions.
  - Bus-ack edge-detect helper constants.
- One natural sub-module: m68k_bus_slave_if. It holds the as edge detect, the one-shot ack, the addr[7:1] decode-valid signal and the byte-lane write enables; it is reusable by the UART.
- The counter and prescaler stay in m68k_timer.

Test Plan:
- Reset: assert reset_n=0 mid-count -> all outputs 0 asynchronously, RELOAD reads FFFF_FFFF after release.
- One-shot: PRESCALE=4, RELOAD=3, CTRL=0x05 -> irq single pulse 16 clks after the RUN write, EXP=1, RUN reads 0, COUNT=0.
- Auto-reload: RELOAD=1, CTRL=0x07 -> irq pulses every 8 clks, at least 4 periods, COUNT sequence 1,0,1,0.
- W1C race: write STATUS=1 in the exact expiry cycle -> EXP remains 1; a later write STATUS=1 -> EXP=0.
- Bus: read COUNT_HI then COUNT_LO while running -> coherent 32-bit snapshot. A uds-only read of CTRL -> data_read=0. Access to addr 0x10 -> no ack. as held 5 clks -> exactly one ack.
- M68K_TIMER_PRESCALER_EN: PRESC=0, RELOAD=2, auto -> irq every 3 clks. Without the macro -> access to 0x0C gets no ack.
